// File: rtl/csel_pkg.sv
// Shared constants and helpers for the pipelined carry-select adder.
package csel_pkg;

  localparam int CSEL_WIDTH = 16;
  localparam int CSEL_SEG   = 4;

  // Default configuration must split into whole segments.
  localparam bit CSEL_WIDTH_OK = (CSEL_WIDTH % CSEL_SEG) == 0;

  function automatic bit csel_width_ok(input int width, input int seg);
    return (seg > 0) && (width >= seg) && ((width % seg) == 0);
  endfunction

  function automatic int csel_nseg(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/csel_pipe_adder_if.sv
// Operand/result bus of the carry-select adder.
// Both sides use plain valid/ready: a transfer happens on a rising edge where valid && ready;
// the sender holds its payload stable while valid is high and ready is low.
interface csel_pipe_adder_if
  import csel_pkg::*;
#(
  parameter int WIDTH = CSEL_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/csel_segment.sv
// One carry-select segment: both candidate sums are formed up front, the incoming carry picks one.
module csel_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           sel_i,
  output logic [SEG-1:0] sum_o,
  output logic           c_o
);

  logic [SEG:0] s0;
  logic [SEG:0] s1;

  assign s0 = {1'b0, a_i} + {1'b0, b_i};
  assign s1 = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, 1'b1};

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    mux_2X1 u_mux (
      .d0_i  (s0[i]),
      .d1_i  (s1[i]),
      .sel_i (sel_i),
      .y_o   (sum_o[i])
    );
  end

  mux_2X1 u_carry_mux (
    .d0_i  (s0[SEG]),
    .d1_i  (s1[SEG]),
    .sel_i (sel_i),
    .y_o   (c_o)
  );

endmodule

module mux_2X1 (
  input  logic d0_i,
  input  logic d1_i,
  input  logic sel_i,
  output logic y_o
);

  assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/csel_pipe_adder.sv
// Pipelined carry-select adder: one SEG-bit segment resolved per stage, valid/ready with full back-pressure.
module csel_pipe_adder
  import csel_pkg::*;
#(
  parameter int WIDTH = CSEL_WIDTH,
  parameter int SEG   = CSEL_SEG
) (
  input  logic               clk,
  input  logic               rst,
  csel_pipe_adder_if.slave   bus
);

  localparam int NSEG = csel_nseg(WIDTH, SEG);

  if (!csel_width_ok(WIDTH, SEG) || !CSEL_WIDTH_OK) begin : g_bad_width
    $error("csel_pipe_adder: WIDTH must be a non-zero multiple of SEG");
  end

  logic             adv;
  logic [NSEG-1:0]  v_q, v_d;
  logic [NSEG-1:0]  c_q, c_d;
  // Each stage word shifts right by SEG: finished sum segments enter at the top,
  // the operand segment for the next stage sits at the bottom.
  logic [WIDTH-1:0] ws_q [NSEG];
  logic [WIDTH-1:0] ws_d [NSEG];
  logic [WIDTH-1:0] wb_q [NSEG];
  logic [WIDTH-1:0] wb_d [NSEG];

  logic [SEG-1:0]   seg_a   [NSEG];
  logic [SEG-1:0]   seg_b   [NSEG];
  logic [SEG-1:0]   seg_sum [NSEG];
  logic [NSEG-1:0]  seg_sel;
  logic [NSEG-1:0]  seg_c;

  assign adv           = !v_q[NSEG-1] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v_q[NSEG-1];
  assign bus.sum       = ws_q[NSEG-1];
  assign bus.cout      = c_q[NSEG-1];

  always_comb begin
    seg_a[0]   = bus.a[SEG-1:0];
    seg_b[0]   = bus.b[SEG-1:0];
    seg_sel[0] = bus.cin;
    for (int k = 1; k < NSEG; k++) begin
      seg_a[k]   = ws_q[k-1][SEG-1:0];
      seg_b[k]   = wb_q[k-1][SEG-1:0];
      seg_sel[k] = c_q[k-1];
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    csel_segment #(.SEG(SEG)) u_seg (
      .a_i   (seg_a[k]),
      .b_i   (seg_b[k]),
      .sel_i (seg_sel[k]),
      .sum_o (seg_sum[k]),
      .c_o   (seg_c[k])
    );
  end

  always_comb begin
    ws_d[0]                 = bus.a >> SEG;
    ws_d[0][WIDTH-1 -: SEG] = seg_sum[0];
    wb_d[0]                 = bus.b >> SEG;
    v_d[0]                  = bus.in_valid && bus.in_ready;
    c_d                     = seg_c;
    for (int k = 1; k < NSEG; k++) begin
      ws_d[k]                 = ws_q[k-1] >> SEG;
      ws_d[k][WIDTH-1 -: SEG] = seg_sum[k];
      wb_d[k]                 = wb_q[k-1] >> SEG;
      v_d[k]                  = v_q[k-1];
    end
  end

  // The whole pipe moves together on adv; bubbles travel like data.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < NSEG; k++) begin
        ws_q[k] <= '0;
        wb_q[k] <= '0;
      end
    end else if (adv) begin
      v_q <= v_d;
      c_q <= c_d;
      for (int k = 0; k < NSEG; k++) begin
        ws_q[k] <= ws_d[k];
        wb_q[k] <= wb_d[k];
      end
    end
  end

endmodule
